// File: rtl/comma_aligner.sv
// comma_aligner: K28.5 symbol aligner ahead of the 8B/10B decoder.
// Optional loss-of-lock counter port los_cnt under `ALIGN_LOS_CNT_EN.
module comma_aligner #(
    parameter int LOCK_COMMAS = 3,
    parameter int MAX_ERRS    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] data_in,
    input  logic       in_valid,
    input  logic       sym_err,
    output logic [9:0] data_out,
    output logic       out_valid,
    output logic       comma_det,
    output logic       locked,
    output logic [3:0] offset
`ifdef ALIGN_LOS_CNT_EN
    ,
    output logic [15:0] los_cnt
`endif
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  prev_q, prev_d;
    logic [3:0]  offset_q, offset_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  err_q, err_d;
    logic [9:0]  dout_q, dout_d;
    logic        cdet_q, cdet_d;
    logic        ovalid_q, ovalid_d;
`ifdef ALIGN_LOS_CNT_EN
    logic [15:0] los_q, los_d;
`endif

    logic [19:0] win;
    logic [9:0]  match;
    logic        comma_any;
    logic [3:0]  det_k;
    logic [3:0]  sel;
    logic [9:0]  cand;
    logic        sel_hit;
    logic [3:0]  cnt_inc;
    logic [3:0]  err_base;
    logic [4:0]  err_sum;
    logic        mis;

    // Comma search over all ten offsets; lowest matching offset wins.
    always_comb begin
        win       = {prev_q, data_in};
        match     = '0;
        det_k     = '0;
        for (int k = 0; k < 10; k++) begin
            match[k] = (win[19-k -: 7] == 7'b0011111) ||
                       (win[19-k -: 7] == 7'b1100000);
        end
        for (int k = 9; k >= 0; k--) begin
            if (match[k]) det_k = 4'(k);
        end
        comma_any = |match;
        sel       = (state_q != LOCKED && comma_any) ? det_k : offset_q;
        cand      = '0;
        sel_hit   = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (sel == 4'(k)) begin
                cand    = win[19-k -: 10];
                sel_hit = match[k];
            end
        end
    end

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        dout_d   = dout_q;
        cdet_d   = cdet_q;
        ovalid_d = in_valid;
`ifdef ALIGN_LOS_CNT_EN
        los_d    = los_q;
`endif
        cnt_inc  = cnt_q + 4'd1;
        mis      = in_valid && comma_any && !sel_hit;
        err_base = (in_valid && sel_hit) ? 4'd0 : err_q;
        err_sum  = {1'b0, err_base} + {4'd0, mis} + {4'd0, sym_err};

        if (in_valid) begin
            prev_d = data_in;
            dout_d = cand;
            cdet_d = sel_hit;
        end

        unique case (state_q)
            HUNT: begin
                if (in_valid && comma_any) begin
                    offset_d = det_k;
                    cnt_d    = 4'd1;
                    if (LOCK_COMMAS == 1) begin
                        state_d = LOCKED;
                        err_d   = 4'd0;
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                if (in_valid && comma_any) begin
                    if (det_k == offset_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(LOCK_COMMAS)) begin
                            state_d = LOCKED;
                            err_d   = 4'd0;
                        end
                    end else begin
                        offset_d = det_k;
                        cnt_d    = 4'd1;
                    end
                end
            end
            LOCKED: begin
                err_d = (err_sum > 5'd15) ? 4'd15 : err_sum[3:0];
                if ({1'b0, err_d} >= 5'(MAX_ERRS)) begin
                    state_d = HUNT;
                    cnt_d   = 4'd0;
                    err_d   = 4'd0;
`ifdef ALIGN_LOS_CNT_EN
                    if (los_q != 16'hFFFF) los_d = los_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            offset_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            dout_q   <= '0;
            cdet_q   <= 1'b0;
            ovalid_q <= 1'b0;
`ifdef ALIGN_LOS_CNT_EN
            los_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            cdet_q   <= cdet_d;
            ovalid_q <= ovalid_d;
`ifdef ALIGN_LOS_CNT_EN
            los_q    <= los_d;
`endif
        end
    end

    assign data_out  = dout_q;
    assign out_valid = ovalid_q;
    assign comma_det = cdet_q;
    assign locked    = (state_q == LOCKED);
    assign offset    = offset_q;
`ifdef ALIGN_LOS_CNT_EN
    assign los_cnt   = los_q;
`endif

endmodule

// File: tb/tb_comma_aligner.sv
// tb_comma_aligner: directed vectors for comma_aligner.
// Optional los_cnt checks under `ALIGN_LOS_CNT_EN.
module tb_comma_aligner;

    localparam logic [9:0] KA = 10'b0011111010;
    localparam logic [9:0] KB = 10'b1100000101;
    localparam logic [9:0] DD = 10'b1010101010;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] data_in;
    logic       in_valid;
    logic       sym_err;
    logic [9:0] data_out;
    logic       out_valid;
    logic       comma_det;
    logic       locked;
    logic [3:0] offset;
`ifdef ALIGN_LOS_CNT_EN
    logic [15:0] los_cnt;
`endif

    always #5 clk = ~clk;

    comma_aligner #(
        .LOCK_COMMAS(3),
        .MAX_ERRS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .in_valid(in_valid),
        .sym_err(sym_err),
        .data_out(data_out),
        .out_valid(out_valid),
        .comma_det(comma_det),
        .locked(locked),
        .offset(offset)
`ifdef ALIGN_LOS_CNT_EN
        ,
        .los_cnt(los_cnt)
`endif
    );

    typedef struct {
        logic       v;
        logic [9:0] din;
        logic [9:0] dout;
        logic       ov;
        logic       cd;
        logic       lk;
        logic [3:0] off;
    } vec_t;

    vec_t       tbl[10];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] last;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [9:0] dout,
                           input logic ov, input logic cd,
                           input logic lk, input logic [3:0] off);
        chk({nm, ".data_out"}, 16'(data_out), 16'(dout));
        chk({nm, ".out_valid"}, 16'(out_valid), 16'(ov));
        chk({nm, ".comma_det"}, 16'(comma_det), 16'(cd));
        chk({nm, ".locked"}, 16'(locked), 16'(lk));
        chk({nm, ".offset"}, 16'(offset), 16'(off));
    endtask

    task automatic step(input logic v, input logic [9:0] d, input logic e);
        in_valid = v;
        data_in  = d;
        sym_err  = e;
        @(posedge clk);
        #1;
    endtask

    // Send the word that carries the tail of 'last' and head of 'sym'
    // so that 'last' sits at bit offset sk of the window.
    task automatic push(input logic [9:0] sym, input int sk);
        logic [19:0] cat;
        cat = {last, sym};
        step(1'b1, cat[9+sk -: 10], 1'b0);
        last = sym;
    endtask

    initial begin
        tbl[0] = '{1'b1, 10'b0100011111, 10'b0000000000, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 10'b0101010101, KA, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[2] = '{1'b1, 10'b0101010101, DD, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[3] = '{1'b1, 10'b0101010101, DD, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[4] = '{1'b1, 10'b0101100000, DD, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[5] = '{1'b1, 10'b1011010101, KB, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[6] = '{1'b1, 10'b0101010101, DD, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[7] = '{1'b1, 10'b0101010101, DD, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[8] = '{1'b1, 10'b0100011111, DD, 1'b1, 1'b0, 1'b0, 4'd3};
        tbl[9] = '{1'b1, 10'b0101010101, KA, 1'b1, 1'b1, 1'b1, 4'd3};

        reset    = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        sym_err  = 1'b0;
        last     = DD;

        for (int i = 0; i < 4; i++) begin
            step(i[0], 10'b0011111010, 1'b0);
            chk_out($sformatf("rst%0d", i), 10'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        end
`ifdef ALIGN_LOS_CNT_EN
        chk("rst.los_cnt", los_cnt, 16'd0);
`endif
        reset = 1'b1;
        step(1'b0, 10'd0, 1'b0);
        chk_out("idle", 10'd0, 1'b0, 1'b0, 1'b0, 4'd0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].din, 1'b0);
            chk_out($sformatf("vec%0d", i), tbl[i].dout, tbl[i].ov,
                    tbl[i].cd, tbl[i].lk, tbl[i].off);
        end
        last = DD;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'd0, 1'b1);
            chk($sformatf("err3_%0d.locked", i), 16'(locked), 16'd1);
        end
        push(KA, 3);
        chk_out("pre_clr", DD, 1'b1, 1'b0, 1'b1, 4'd3);
        push(DD, 3);
        chk_out("clr", KA, 1'b1, 1'b1, 1'b1, 4'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'd0, 1'b1);
            chk($sformatf("err_%0d.locked", i), 16'(locked), 16'd1);
        end
        step(1'b0, 10'd0, 1'b1);
        chk_out("los", KA, 1'b0, 1'b1, 1'b0, 4'd3);
`ifdef ALIGN_LOS_CNT_EN
        chk("los.los_cnt", los_cnt, 16'd1);
`endif

        push(KA, 3);
        chk("rl0.locked", 16'(locked), 16'd0);
        push(DD, 3);
        chk_out("rl1", KA, 1'b1, 1'b1, 1'b0, 4'd3);
        push(KB, 3);
        push(DD, 3);
        chk_out("rl2", KB, 1'b1, 1'b1, 1'b0, 4'd3);
        push(DD, 5);
        chk("rl3.locked", 16'(locked), 16'd0);
        push(KA, 5);
        push(DD, 5);
        chk_out("rl5", KA, 1'b1, 1'b1, 1'b0, 4'd5);
        push(KB, 5);
        push(DD, 5);
        chk_out("rl6", KB, 1'b1, 1'b1, 1'b0, 4'd5);
        push(KA, 5);
        push(DD, 5);
        chk_out("rl7", KA, 1'b1, 1'b1, 1'b1, 4'd5);

        push(KA, 5);
        chk_out("gap0", DD, 1'b1, 1'b0, 1'b1, 4'd5);
        step(1'b0, 10'b1111100000, 1'b0);
        chk_out("gap1", DD, 1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b0, 10'b0000011111, 1'b0);
        chk_out("gap2", DD, 1'b0, 1'b0, 1'b1, 4'd5);
        push(DD, 5);
        chk_out("gap3", KA, 1'b1, 1'b1, 1'b1, 4'd5);

        #2;
        reset = 1'b0;
        #1;
        chk_out("arst", 10'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 10'b0011111010, 1'b0);
        step(1'b0, 10'b1100000101, 1'b1);
        chk_out("arst_hold", 10'd0, 1'b0, 1'b0, 1'b0, 4'd0);
`ifdef ALIGN_LOS_CNT_EN
        chk("arst.los_cnt", los_cnt, 16'd0);
`endif
        reset = 1'b1;
        step(1'b0, 10'd0, 1'b0);
        chk_out("arst_idle", 10'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        last = DD;
        push(DD, 5);
        chk_out("re0", 10'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        push(KA, 5);
        push(DD, 5);
        chk_out("re1", KA, 1'b1, 1'b1, 1'b0, 4'd5);
        push(KB, 5);
        push(DD, 5);
        chk_out("re2", KB, 1'b1, 1'b1, 1'b0, 4'd5);
        push(KA, 5);
        push(DD, 5);
        chk_out("re3", KA, 1'b1, 1'b1, 1'b1, 4'd5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
